// File: rtl/gpio_event_ctrl.sv
// GPIO block with APB register access, input synchronisation, per-channel debounce
// and edge-event capture into a write-one-to-clear pending register driving a level irq.
module gpio_event_ctrl #(
    parameter int NGPIO       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NGPIO-1:0] gpio_in,
    output logic [NGPIO-1:0] gpio_out,
    output logic [NGPIO-1:0] gpio_dir,
    input  logic             psel,
    input  logic             penable,
    input  logic             pwrite,
    input  logic [4:0]       paddr,
    input  logic [31:0]      pwdata,
    output logic [31:0]      prdata,
    output logic             pready,
    output logic             pslverr,
    output logic             irq_o
);

    localparam logic [2:0] A_DIR    = 3'd0;
    localparam logic [2:0] A_OUT    = 3'd1;
    localparam logic [2:0] A_IN     = 3'd2;
    localparam logic [2:0] A_INTEN  = 3'd3;
    localparam logic [2:0] A_RISE   = 3'd4;
    localparam logic [2:0] A_FALL   = 3'd5;
    localparam logic [2:0] A_PEND   = 3'd6;
    localparam logic [2:0] A_DEBCFG = 3'd7;

    logic [NGPIO-1:0] r_dir, r_out, r_inten, r_rise_en, r_fall_en, r_pending;
    logic [DEB_W-1:0] r_debcfg;
    logic [NGPIO-1:0] r_sync [SYNC_STAGES];
    logic [NGPIO-1:0] r_stable, r_stable_d;
    logic [DEB_W-1:0] r_cnt [NGPIO];

    logic [2:0]       w_addr;
    logic             w_wr;
    logic [NGPIO-1:0] w_wdata;
    logic [NGPIO-1:0] w_sync;
    logic [NGPIO-1:0] w_set, w_clr;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_addr   = paddr[4:2];
    assign w_wr     = psel & penable & pwrite;
    assign w_wdata  = pwdata[NGPIO-1:0];
    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_unused = &{1'b0, paddr[1:0], pwdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir     <= '0;
            r_out     <= '0;
            r_inten   <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_debcfg  <= '0;
        end else if (w_wr) begin
            case (w_addr)
                A_DIR:    r_dir     <= w_wdata;
                A_OUT:    r_out     <= w_wdata;
                A_INTEN:  r_inten   <= w_wdata;
                A_RISE:   r_rise_en <= w_wdata;
                A_FALL:   r_fall_en <= w_wdata;
                A_DEBCFG: r_debcfg  <= pwdata[DEB_W-1:0];
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    // ">=" rather than "==" so a threshold lowered below a running count
    // still accepts the new level on the next mismatching edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable   <= '0;
            r_stable_d <= '0;
            for (int i = 0; i < NGPIO; i++) r_cnt[i] <= '0;
        end else begin
            r_stable_d <= r_stable;
            for (int i = 0; i < NGPIO; i++) begin
                if (w_sync[i] != r_stable[i]) begin
                    if (r_cnt[i] >= r_debcfg) begin
                        r_stable[i] <= w_sync[i];
                        r_cnt[i]    <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_set = (r_stable & ~r_stable_d & r_rise_en) | (~r_stable & r_stable_d & r_fall_en);
    assign w_clr = (w_wr && (w_addr == A_PEND)) ? w_wdata : '0;

    // Clear applied before set so a same-edge event survives the W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= (r_pending & ~w_clr) | w_set;
    end

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            A_DIR:    w_rdata[NGPIO-1:0] = r_dir;
            A_OUT:    w_rdata[NGPIO-1:0] = r_out;
            A_IN:     w_rdata[NGPIO-1:0] = r_stable;
            A_INTEN:  w_rdata[NGPIO-1:0] = r_inten;
            A_RISE:   w_rdata[NGPIO-1:0] = r_rise_en;
            A_FALL:   w_rdata[NGPIO-1:0] = r_fall_en;
            A_PEND:   w_rdata[NGPIO-1:0] = r_pending;
            A_DEBCFG: w_rdata[DEB_W-1:0] = r_debcfg;
            default:  w_rdata = '0;
        endcase
    end

    assign prdata   = (psel && !pwrite) ? w_rdata : 32'd0;
    assign pready   = 1'b1;
    assign pslverr  = w_wr && (w_addr == A_IN);
    assign irq_o    = |(r_pending & r_inten);
    assign gpio_dir = r_dir;
    assign gpio_out = r_out;

endmodule

// File: tb/tb_gpio_event_ctrl.sv
// Directed bench for gpio_event_ctrl: a 32-channel instance for the event path
// and an 8-channel, 4-bit-debounce instance for register width masking.
module tb_gpio_event_ctrl;

    localparam logic [4:0] R_DIR    = 5'h00;
    localparam logic [4:0] R_OUT    = 5'h04;
    localparam logic [4:0] R_IN     = 5'h08;
    localparam logic [4:0] R_INTEN  = 5'h0C;
    localparam logic [4:0] R_RISE   = 5'h10;
    localparam logic [4:0] R_FALL   = 5'h14;
    localparam logic [4:0] R_PEND   = 5'h18;
    localparam logic [4:0] R_DEBCFG = 5'h1C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel0, psel1, penable, pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata;

    logic [31:0] gpio_in0, gpio_out0, gpio_dir0, prdata0;
    logic        pready0, pslverr0, irq0;
    logic [7:0]  gpio_in1, gpio_out1, gpio_dir1;
    logic [31:0] prdata1;
    logic        pready1, pslverr1, irq1;

    int checks   = 0;
    int failures = 0;
    logic [31:0] d;

    always #5 clk = ~clk;

    gpio_event_ctrl #(.NGPIO(32), .SYNC_STAGES(2), .DEB_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .gpio_in(gpio_in0), .gpio_out(gpio_out0),
        .gpio_dir(gpio_dir0), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
        .pslverr(pslverr0), .irq_o(irq0)
    );

    gpio_event_ctrl #(.NGPIO(8), .SYNC_STAGES(2), .DEB_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .gpio_in(gpio_in1), .gpio_out(gpio_out1),
        .gpio_dir(gpio_dir1), .psel(psel1), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata1), .pready(pready1),
        .pslverr(pslverr1), .irq_o(irq1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Read with no clock consumed: prdata is combinational during psel & !pwrite.
    task automatic rd(input bit inst, input logic [4:0] a, output logic [31:0] v);
        psel0   = !inst;
        psel1   = inst;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = a;
        #1;
        v = inst ? prdata1 : prdata0;
        psel0 = 1'b0;
        psel1 = 1'b0;
    endtask

    // Called between edges; returns at the negedge after the commit edge.
    task automatic wr(input bit inst, input logic [4:0] a, input logic [31:0] v);
        psel0   = !inst;
        psel1   = inst;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = a;
        pwdata  = v;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel0   = 1'b0;
        psel1   = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; gpio_in0 = '0; gpio_in1 = 8'h5A;
        #1;
        chk("rst_gpio_dir", gpio_dir0, 32'h0);
        chk("rst_irq", {31'd0, irq0}, 32'h0);
        chk("pready", {31'd0, pready0}, 32'h1);
        step(2);
        rst_n = 1'b1;
        rd(0, R_PEND, d);  chk("rst_pending", d, 32'h0);
        rd(0, R_DEBCFG, d); chk("rst_debcfg", d, 32'h0);

        // Rise on channel 0 with DEBCFG=0: IN after 3 edges, PENDING/irq after 4
        wr(0, R_RISE, 32'h1);
        wr(0, R_INTEN, 32'h1);
        gpio_in0[0] = 1'b1;
        step(2);
        rd(0, R_IN, d);   chk("rise_in_e2", d, 32'h0);
        step(1);
        rd(0, R_IN, d);   chk("rise_in_e3", d, 32'h1);
        rd(0, R_PEND, d); chk("rise_pend_e3", d, 32'h0);
        step(1);
        rd(0, R_PEND, d); chk("rise_pend_e4", d, 32'h1);
        chk("rise_irq_e4", {31'd0, irq0}, 32'h1);

        // Debounce with DEBCFG=4 on channel 5
        wr(0, R_PEND, 32'h1);
        chk("w1c_irq", {31'd0, irq0}, 32'h0);
        gpio_in0[5] = 1'b1;
        step(6);
        wr(0, R_DEBCFG, 32'h4);
        wr(0, R_FALL, 32'h20);
        rd(0, R_IN, d);   chk("deb_in_init", d, 32'h21);
        gpio_in0[5] = 1'b0;
        step(3);
        gpio_in0[5] = 1'b1;
        step(12);
        rd(0, R_IN, d);   chk("glitch_in", d, 32'h21);
        rd(0, R_PEND, d); chk("glitch_pend", d, 32'h0);
        gpio_in0[5] = 1'b0;
        step(6);
        rd(0, R_IN, d);   chk("fall_in_e6", d, 32'h21);
        gpio_in0[5] = 1'b1;
        step(1);
        rd(0, R_IN, d);   chk("fall_in_e7", d, 32'h01);
        rd(0, R_PEND, d); chk("fall_pend_e7", d, 32'h0);
        step(1);
        rd(0, R_PEND, d); chk("fall_pend_e8", d, 32'h20);
        step(10);
        rd(0, R_IN, d);   chk("fall_recover_in", d, 32'h21);

        // Simultaneous rises on channels 0/1, W1C, and same-edge set vs clear
        wr(0, R_PEND, 32'hFFFF_FFFF);
        wr(0, R_DEBCFG, 32'h0);
        wr(0, R_FALL, 32'h0);
        gpio_in0[1:0] = 2'b00;
        step(6);
        wr(0, R_RISE, 32'h3);
        gpio_in0[1:0] = 2'b11;
        step(6);
        rd(0, R_PEND, d); chk("multi_pend", d, 32'h3);
        wr(0, R_INTEN, 32'h2);
        chk("inten2_irq", {31'd0, irq0}, 32'h1);
        wr(0, R_PEND, 32'h2);
        rd(0, R_PEND, d); chk("w1c_bit1", d, 32'h1);
        chk("w1c_bit1_irq", {31'd0, irq0}, 32'h0);
        gpio_in0[1] = 1'b0;
        step(6);
        gpio_in0[1] = 1'b1;
        step(2);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = R_PEND; pwdata = 32'h2;
        step(1);
        penable = 1'b1;
        step(1);
        psel0 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        rd(0, R_PEND, d); chk("set_wins_pend", d, 32'h3);
        chk("set_wins_irq", {31'd0, irq0}, 32'h1);

        // Lowering DEBCFG below a running count on channel 2
        wr(0, R_DEBCFG, 32'hF);
        gpio_in0[2] = 1'b1;
        step(6);
        rd(0, R_IN, d);   chk("lower_in_before", d & 32'h4, 32'h0);
        wr(0, R_DEBCFG, 32'h2);
        rd(0, R_IN, d);   chk("lower_in_commit", d & 32'h4, 32'h0);
        step(1);
        rd(0, R_IN, d);   chk("lower_in_next", d & 32'h4, 32'h4);

        // Narrow instance: width masking and write to IN
        wr(1, R_DIR, 32'hFFFF_FFFF);
        rd(1, R_DIR, d);  chk("n8_dir_read", d, 32'hFF);
        chk("n8_gpio_dir", {24'd0, gpio_dir1}, 32'hFF);
        wr(1, R_OUT, 32'h1234_5678);
        rd(1, R_OUT, d);  chk("n8_out_read", d, 32'h78);
        chk("n8_gpio_out", {24'd0, gpio_out1}, 32'h78);
        wr(1, R_DEBCFG, 32'hFFFF);
        rd(1, R_DEBCFG, d); chk("n8_debcfg_read", d, 32'hF);
        rd(1, R_IN, d);   chk("n8_in_before", d, 32'h5A);
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = R_IN; pwdata = 32'hFFFF_FFFF;
        #1;
        chk("slverr_setup", {31'd0, pslverr1}, 32'h0);
        step(1);
        penable = 1'b1;
        #1;
        chk("slverr_access", {31'd0, pslverr1}, 32'h1);
        chk("slverr_other_inst", {31'd0, pslverr0}, 32'h0);
        step(1);
        psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        #1;
        chk("slverr_idle", {31'd0, pslverr1}, 32'h0);
        rd(1, R_IN, d);   chk("n8_in_after", d, 32'h5A);

        // Reset mid-count, then a rise from pads held high through release
        wr(0, R_DIR, 32'hA5);
        wr(0, R_OUT, 32'h5A);
        chk("pre_rst_dir", gpio_dir0, 32'hA5);
        psel0 = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = R_DIR;
        #1;
        chk("prdata_zero_on_write", prdata0, 32'h0);
        psel0 = 1'b0; pwrite = 1'b0;
        wr(0, R_DEBCFG, 32'h4);
        gpio_in0[3] = 1'b1;
        step(3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dir", gpio_dir0, 32'h0);
        chk("async_rst_out", gpio_out0, 32'h0);
        chk("async_rst_irq", {31'd0, irq0}, 32'h0);
        chk("async_rst_n8_dir", {24'd0, gpio_dir1}, 32'h0);
        step(2);
        rd(0, R_PEND, d); chk("in_rst_pend", d, 32'h0);
        rst_n = 1'b1;
        wr(0, R_RISE, 32'hFFFF_FFFF);
        rd(0, R_PEND, d); chk("post_rst_pend_e2", d, 32'h0);
        step(1);
        rd(0, R_IN, d);   chk("post_rst_in_e3", d, 32'h2F);
        rd(0, R_PEND, d); chk("post_rst_pend_e3", d, 32'h0);
        step(1);
        rd(0, R_PEND, d); chk("post_rst_pend_e4", d, 32'h2F);
        chk("post_rst_irq", {31'd0, irq0}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_event_ctrl.md
GPIO_EVENT_CTRL -- requirements
Module: gpio_event_ctrl

Interface
REQ-001 SHALL have parameter NGPIO, default 32, number of GPIO channels (legal 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (legal 2..3).
REQ-003 SHALL have parameter DEB_W, default 8, debounce counter and threshold width (legal 1..16).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 gpio_in  in  NGPIO  asynchronous pad inputs.
REQ-007 gpio_out  out  NGPIO  pad output values, registered.
REQ-008 gpio_dir  out  NGPIO  pad direction, 1 = output, registered.
REQ-009 psel, penable, pwrite  in  1 each  APB control.
REQ-010 paddr  in  5  byte address; bits [1:0] ignored.
REQ-011 pwdata  in  32  write data.
REQ-012 prdata  out  32  read data, combinational.
REQ-013 pready  out  1  tied 1 (zero wait states).
REQ-014 pslverr  out  1  error response.
REQ-015 irq_o  out  1  level interrupt.

Function
REQ-016 Register map SHALL be: 0x00 DIR RW, 0x04 OUT RW, 0x08 IN RO (debounced), 0x0C INTEN RW, 0x10 RISE_EN RW, 0x14 FALL_EN RW, 0x18 PENDING RO/W1C, 0x1C DEBCFG RW (bits [DEB_W-1:0]).
REQ-017 Write SHALL commit on the clk edge where psel&penable&pwrite; prdata SHALL be valid whenever psel&!pwrite, and 0 otherwise.
REQ-018 Register bits at or above NGPIO (DEB_W for DEBCFG) SHALL read 0 and ignore writes.
REQ-019 pslverr SHALL be 1 only during an access phase write to IN; that write SHALL have no effect.
REQ-020 gpio_dir and gpio_out SHALL equal DIR and OUT directly.
REQ-021 Each channel SHALL pass through SYNC_STAGES flops; sync output visible SYNC_STAGES edges after an input change is first sampled.
REQ-022 Debounce per channel: while sync != stable, counter increments each edge; stable takes sync on the edge where counter == DEBCFG, counter clears; sync == stable clears counter.
REQ-023 Debounce consequence: a new level is accepted after DEBCFG+1 consecutive mismatching sync cycles; DEBCFG=0 means stable follows sync with 1 edge delay.
REQ-024 Glitches shorter than DEBCFG+1 sync cycles SHALL not change stable or set pending.
REQ-025 If DEBCFG is lowered below a running count, stable SHALL update on the next edge with mismatch.
REQ-026 Rise event = stable 0->1; fall event = stable 1->0; PENDING[i] SHALL set on the edge after an event enabled by RISE_EN[i]/FALL_EN[i], independent of INTEN.
REQ-027 PENDING W1C: writing 1 clears bit; same-edge set and clear SHALL leave bit set (set wins).
REQ-028 irq_o SHALL equal OR of (PENDING & INTEN), combinational from registers.
REQ-029 Total latency gpio_in change to IN read = SYNC_STAGES+DEBCFG+1 edges; to PENDING/irq_o = SYNC_STAGES+DEBCFG+2 edges.
REQ-030 Channels SHALL be fully independent; simultaneous events on several channels SHALL each set their own bit.

Reset
REQ-031 rst_n low SHALL asynchronously clear DIR, OUT, INTEN, RISE_EN, FALL_EN, PENDING, DEBCFG, sync flops, stable, counters; irq_o=0, gpio_dir=0, gpio_out=0, pslverr=0.
REQ-032 Reset mid-debounce SHALL discard the count; a pad held high through reset release SHALL produce a rise event after the REQ-029 latency.
REQ-033 Reset release SHALL be synchronous to clk by the integrating SoC; no internal reset synchroniser.

Verification
REQ-034 NGPIO=32, SYNC=2, DEBCFG=0, RISE_EN=INTEN=0x1; gpio_in[0] 0->1 -> IN[0]=1 after 3 edges, PENDING=0x1 and irq_o=1 after 4.
REQ-035 DEBCFG=4, FALL_EN[5]=1; 3-cycle low pulse on gpio_in[5] -> no change; 6-cycle low -> IN[5]=0 after 7 edges, PENDING[5]=1.
REQ-036 PENDING=0x3, INTEN=0x2; write 0x2 to 0x18 -> PENDING=0x1, irq_o=0; write-clear same edge as new bit1 rise -> bit1 remains 1.
REQ-037 NGPIO=8; write 0xFFFFFFFF to DIR -> read 0x000000FF, gpio_dir=0xFF; write to 0x08 -> pslverr=1, IN unchanged.
REQ-038 rst_n asserted mid-count with DIR=0xA5 -> all outputs 0 immediately; pad high at release -> rise pending after 4 edges (DEBCFG=0).
